// File: rtl/stopwatch_ctrl_if.sv
// Button, overflow and control/status signals between the stopwatch
// controller (slave) and the logic that drives it and consumes its outputs (master).
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lr;
    logic       ovf_in;
    logic       tick;
    logic       cnt_clr;
    logic       lap_hold;
    logic       ovf;
    logic [1:0] state;

    modport master (
        output btn_ss, btn_lr, ovf_in,
        input  tick, cnt_clr, lap_hold, ovf, state
    );

    modport slave (
        input  btn_ss, btn_lr, ovf_in,
        output tick, cnt_clr, lap_hold, ovf, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: decodes start/stop and lap/reset pulses, prescales
// clk into the counter-chain tick, and raises clear, lap-freeze and overflow.
module stopwatch_ctrl #(
    parameter int DIV   = 1000000,
    parameter int DIV_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] P_MAX = DIV_W'(DIV - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] p_q, p_d;
    logic             tick_q, tick_d;
    logic             clr_q, clr_d;
    logic             hold_q, hold_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        clr_d   = 1'b0;
        p_d     = p_q;
        tick_d  = 1'b0;

        // btn_ss is tested before btn_lr everywhere, so it wins a simultaneous press.
        case (state_q)
            IDLE: begin
                if (bus.btn_ss) state_d = RUN;
            end
            RUN: begin
                if (bus.ovf_in) begin
                    state_d = STOP;
                    ovf_d   = 1'b1;
                end else if (bus.btn_ss) begin
                    state_d = STOP;
                end else if (bus.btn_lr) begin
                    state_d = LAP;
                    hold_d  = 1'b1;
                end
            end
            LAP: begin
                if (bus.ovf_in) begin
                    state_d = STOP;
                    ovf_d   = 1'b1;
                    hold_d  = 1'b0;
                end else if (bus.btn_ss) begin
                    state_d = STOP;
                    hold_d  = 1'b0;
                end else if (bus.btn_lr) begin
                    state_d = RUN;
                    hold_d  = 1'b0;
                end
            end
            STOP: begin
                if (bus.btn_ss) begin
                    if (!ovf_q) state_d = RUN;
                end else if (bus.btn_lr) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Prescaler acts on the current state; STOP keeps the partial period.
        if (state_q == RUN || state_q == LAP) begin
            if (p_q == P_MAX) begin
                p_d    = '0;
                tick_d = 1'b1;
            end else begin
                p_d = p_q + DIV_W'(1);
            end
        end else if (state_q == IDLE || clr_d) begin
            p_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
            hold_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q <= state_d;
            p_q     <= p_d;
            tick_q  <= tick_d;
            clr_q   <= clr_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.tick     = tick_q;
    assign bus.cnt_clr  = clr_q;
    assign bus.lap_hold = hold_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4: inputs change on the falling
// edge, outputs are checked on the falling edge after the rising edge under test.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DIV(4), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {state, tick, cnt_clr, lap_hold, ovf}
    function automatic logic [5:0] outs();
        return {bus.state, bus.tick, bus.cnt_clr, bus.lap_hold, bus.ovf};
    endfunction

    // Hold the given inputs across one rising edge, then release them.
    task automatic press(input logic ss, input logic lr, input logic ov);
        bus.btn_ss = ss;
        bus.btn_lr = lr;
        bus.ovf_in = ov;
        @(negedge clk);
        bus.btn_ss = 1'b0;
        bus.btn_lr = 1'b0;
        bus.ovf_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold got %b expected %b", outs(), 6'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 6'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d got %b expected %b", i, outs(), 6'b0);
            end
        end
    endtask

    task automatic test_start();
        press(1, 0, 0);
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL start_edge0 got %b expected %b", outs(), 6'b010000);
        end
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== ((e % 4) == 0)) begin
                errors++;
                $display("FAIL start_tick edge %0d got %b expected %b", e, bus.tick, ((e % 4) == 0));
            end
        end
        press(1, 0, 0);
        press(0, 1, 0);
    endtask

    task automatic test_stop_resume();
        press(1, 0, 0);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (e == 4)) begin
                errors++;
                $display("FAIL sr_tick edge %0d got %b expected %b", e, bus.tick, (e == 4));
            end
        end
        press(1, 0, 0);
        checks++;
        if (outs() !== 6'b100000) begin
            errors++;
            $display("FAIL sr_stop got %b expected %b", outs(), 6'b100000);
        end
        for (int e = 7; e <= 15; e++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 6'b100000) begin
                errors++;
                $display("FAIL sr_hold edge %0d got %b expected %b", e, outs(), 6'b100000);
            end
        end
        press(1, 0, 0);
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL sr_resume got %b expected %b", outs(), 6'b010000);
        end
        for (int e = 17; e <= 19; e++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (e == 18)) begin
                errors++;
                $display("FAIL sr_fraction edge %0d got %b expected %b", e, bus.tick, (e == 18));
            end
        end
        press(1, 0, 0);
        press(0, 1, 0);
    endtask

    task automatic test_lap();
        press(1, 0, 0);
        @(negedge clk);
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b110010) begin
            errors++;
            $display("FAIL lap_enter got %b expected %b", outs(), 6'b110010);
        end
        for (int t = 3; t <= 9; t++) begin
            @(negedge clk);
            checks++;
            if (outs() !== {2'b11, ((t % 4) == 0), 3'b010}) begin
                errors++;
                $display("FAIL lap_count t %0d got %b expected %b", t, outs(), {2'b11, ((t % 4) == 0), 3'b010});
            end
        end
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL lap_leave got %b expected %b", outs(), 6'b010000);
        end
        for (int t = 11; t <= 12; t++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (t == 12)) begin
                errors++;
                $display("FAIL lap_after t %0d got %b expected %b", t, bus.tick, (t == 12));
            end
        end
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b000000) begin
            errors++;
            $display("FAIL lr_in_idle got %b expected %b", outs(), 6'b000000);
        end
    endtask

    task automatic test_clear();
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 1, 0);
        checks++;
        if (outs() !== 6'b010000) begin
            errors++;
            $display("FAIL both_buttons got %b expected %b", outs(), 6'b010000);
        end
        press(1, 0, 0);
        @(negedge clk);
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b000100) begin
            errors++;
            $display("FAIL clear_pulse got %b expected %b", outs(), 6'b000100);
        end
        @(negedge clk);
        checks++;
        if (bus.cnt_clr !== 1'b0) begin
            errors++;
            $display("FAIL clear_one_cycle got %b expected %b", bus.cnt_clr, 1'b0);
        end
        // Prescaler held 2 before the clear; a full period proves it restarted from 0.
        press(1, 0, 0);
        for (int f = 1; f <= 4; f++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (f == 4)) begin
                errors++;
                $display("FAIL clear_p_zero edge %0d got %b expected %b", f, bus.tick, (f == 4));
            end
        end
        press(1, 0, 0);
        press(0, 1, 0);
    endtask

    task automatic test_back_to_back();
        press(1, 0, 0);
        repeat (3) @(negedge clk);
        press(1, 0, 0);
        checks++;
        if (outs() !== 6'b101000) begin
            errors++;
            $display("FAIL inflight_tick got %b expected %b", outs(), 6'b101000);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 6'b100000) begin
                errors++;
                $display("FAIL no_tick_after_stop cycle %0d got %b expected %b", i, outs(), 6'b100000);
            end
        end
        press(0, 1, 0);
    endtask

    task automatic test_overflow();
        press(1, 0, 0);
        press(1, 0, 1);
        checks++;
        if (outs() !== 6'b100001) begin
            errors++;
            $display("FAIL ovf_run got %b expected %b", outs(), 6'b100001);
        end
        press(1, 0, 0);
        checks++;
        if (outs() !== 6'b100001) begin
            errors++;
            $display("FAIL ovf_ss_ignored got %b expected %b", outs(), 6'b100001);
        end
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b000100) begin
            errors++;
            $display("FAIL ovf_clear got %b expected %b", outs(), 6'b000100);
        end
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 1);
        checks++;
        if (outs() !== 6'b100001) begin
            errors++;
            $display("FAIL ovf_lap got %b expected %b", outs(), 6'b100001);
        end
        press(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 6'b100001) begin
                errors++;
                $display("FAIL ovf_stuck cycle %0d got %b expected %b", i, outs(), 6'b100001);
            end
        end
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b000100) begin
            errors++;
            $display("FAIL ovf_lap_clear got %b expected %b", outs(), 6'b000100);
        end
    endtask

    task automatic test_mid_reset();
        press(1, 0, 0);
        @(negedge clk);
        press(0, 1, 0);
        checks++;
        if (outs() !== 6'b110010) begin
            errors++;
            $display("FAIL pre_reset got %b expected %b", outs(), 6'b110010);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got %b expected %b", outs(), 6'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b expected %b", outs(), 6'b0);
        end
    endtask

    initial begin
        bus.btn_ss = 1'b0;
        bus.btn_lr = 1'b0;
        bus.ovf_in = 1'b0;
        test_reset();
        test_start();
        test_stop_resume();
        test_lap();
        test_clear();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
